// File: rtl/barrett_reduce_pipe_pkg.sv
// Shared Kyber arithmetic constants and coefficient/product types for the
// Barrett reduction datapath.
package barrett_reduce_pipe_pkg;
  localparam int unsigned KYBER_Q   = 3329;
  localparam int unsigned BARRETT_M = 5039;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned COEF_W    = 12;
  localparam int unsigned PROD_W    = 24;
  // M and the quotient estimate both fit in 13 bits; t = x*M needs 37.
  localparam int unsigned MREF_W    = 13;
  localparam int unsigned T_W       = PROD_W + MREF_W;
  localparam int unsigned R0_W      = COEF_W + 1;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [R0_W-1:0]   r0_t;
  typedef logic [T_W-1:0]    barrett_t;
endpackage

// File: rtl/barrett_csub.sv
// Conditional subtract of q: folds a value in [0, 2q) into [0, q).
// Purely combinational so it can sit in any pipeline stage.
module barrett_csub
  import barrett_reduce_pipe_pkg::*;
(
  input  r0_t   i_r0,
  output coef_t o_r
);
  assign o_r = (i_r0 >= R0_W'(KYBER_Q)) ? COEF_W'(i_r0 - R0_W'(KYBER_Q))
                                        : i_r0[COEF_W-1:0];
endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reduction mod 3329 with a global-stall valid/ready
// pipeline and a tag carried alongside each product.
module barrett_reduce_pipe
  import barrett_reduce_pipe_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  prod_t            in_prod,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output coef_t            out_res,
  output logic [TAG_W-1:0] out_tag
);
  logic             r_v1, r_v2, r_v3;
  prod_t            r_x1;
  barrett_t         r_t1;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  r0_t              r_r0_2;
  coef_t            r_res3;

  logic              w_advance;
  barrett_t          w_t;
  logic [MREF_W-1:0] w_qhat;
  prod_t             w_qq;
  r0_t               w_r0;
  coef_t             w_res;

  assign w_advance = !r_v3 || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v3;
  assign out_res   = r_res3;
  assign out_tag   = r_tag3;

  assign w_t    = T_W'(in_prod) * T_W'(BARRETT_M);
  assign w_qhat = MREF_W'(r_t1 >> BARRETT_K);
  assign w_qq   = PROD_W'(w_qhat) * PROD_W'(KYBER_Q);
  // The true difference is below 2q, so modulo-2^13 arithmetic is exact.
  assign w_r0   = R0_W'(r_x1 - w_qq);

  barrett_csub u_csub (
    .i_r0 (r_r0_2),
    .o_r  (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Data only loads behind a valid item, so idle stages stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1   <= '0;
      r_t1   <= '0;
      r_tag1 <= '0;
    end else if (w_advance && in_valid) begin
      r_x1   <= in_prod;
      r_t1   <= w_t;
      r_tag1 <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0_2 <= '0;
      r_tag2 <= '0;
    end else if (w_advance && r_v1) begin
      r_r0_2 <= w_r0;
      r_tag2 <= r_tag1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res3 <= '0;
      r_tag3 <= '0;
    end else if (w_advance && r_v2) begin
      r_res3 <= w_res;
      r_tag3 <= r_tag2;
    end
  end
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe: accepted products push x mod q,
// delivered results pop and compare in order.
module tb_barrett_reduce_pipe;
  localparam int TAG_W = 8;
  localparam int Q     = 3329;
  localparam int QSQ   = 11082241;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [23:0]      in_prod = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [11:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [11:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;

  int dir_x[5] = '{0, 3329, 3330, 1000000, 11075584};
  int dir_r[5] = '{0, 0, 1, 1300, 1};
  int bp_x[6]  = '{11082240, 3328, 11078912, 7, 6658, 5000000};

  always #5 clk = ~clk;

  barrett_reduce_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  // Monitor: transfers are decided by the values stable at the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got res=%0d tag=%0d, required no output", out_res, out_tag);
      end else begin
        mon_e = sb.pop_front();
        if (out_res !== mon_e.res || out_tag !== mon_e.tag) begin
          errors++;
          $display("FAIL sb_data: got res=%0d tag=%0d, required res=%0d tag=%0d",
                   out_res, out_tag, mon_e.res, mon_e.tag);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - mon_e.cyc != 3) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 3", cyc - mon_e.cyc);
          end
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      mon_e.res = 12'(in_prod % 24'(Q));
      mon_e.tag = in_tag;
      mon_e.cyc = cyc;
      sb.push_back(mon_e);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 12'd0 || out_tag !== '0) begin
        errors++;
        $display("FAIL idle: got out_valid=%b in_ready=%b out_res=%0d out_tag=%0d, required 0 1 0 0",
                 out_valid, in_ready, out_res, out_tag);
      end
    end
  endtask

  task automatic test_directed();
    int k = 0;
    chk_lat = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 5) begin
        in_valid = 1'b1;
        in_prod  = 24'(dir_x[c]);
        in_tag   = 8'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (k >= 5 || c != k + 3 || out_res !== 12'(dir_r[k % 5]) || out_tag !== 8'(k + 1)) begin
          errors++;
          $display("FAIL directed: got res=%0d tag=%0d at cycle %0d, required res=%0d tag=%0d at cycle %0d",
                   out_res, out_tag, c, dir_r[k % 5], k + 1, k + 3);
        end
        k++;
      end
    end
    checks++;
    if (k != 5 || sb.size() != 0) begin
      errors++;
      $display("FAIL directed_count: got %0d results (%0d pending), required 5 (0 pending)", k, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    logic [11:0] hold_res = '0;
    logic [7:0]  hold_tag = '0;
    chk_lat = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 6);
      in_prod   = 24'(bp_x[sent % 6]);
      in_tag    = 8'(16 + sent);
      @(negedge clk);
      if (c == 3) begin
        hold_res = out_res;
        hold_tag = out_tag;
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall: got out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (out_res !== hold_res || out_tag !== hold_tag) begin
          errors++;
          $display("FAIL bp_stable: got res=%0d tag=%0d, required res=%0d tag=%0d",
                   out_res, out_tag, hold_res, hold_tag);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got sent=%0d pending=%0d, required 6 0", sent, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int run = 0;
    int best = 0;
    chk_lat = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); #1;
      in_valid = (sent < 100);
      in_prod  = 24'($urandom_range(0, QSQ - 1));
      in_tag   = 8'(c);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        run++;
        checks++;
        if (out_res > 12'd3328) begin
          errors++;
          $display("FAIL b2b_range: got res=%0d, required <= 3328", out_res);
        end
      end else begin
        run = 0;
      end
      if (run > best) best = run;
    end
    in_valid = 1'b0;
    chk_lat = 1'b0;
    checks++;
    if (best != 100 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_throughput: got run=%0d pending=%0d, required 100 0", best, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    chk_lat = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_prod  = 24'($urandom_range(0, QSQ - 1));
      in_tag   = 8'(8'hA0 + c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: got out_valid=%b, required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    sb.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale: got out_valid=%b, required 0", out_valid);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_prod  = 24'($urandom_range(0, QSQ - 1));
      in_tag   = 8'(8'hB0 + c);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_resume: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_random();
    int sent = 0;
    chk_lat = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_prod   = 24'($urandom_range(0, QSQ - 1));
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (sent != 10000 || sb.size() != 0) begin
      errors++;
      $display("FAIL random: got sent=%0d pending=%0d, required 10000 0", sent, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
